// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-system types: RAM status, data word and arbiter FSM states.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between icache and dcache, data-priority by default.
// Define ARB_FAIR_EN to bound consecutive data grants while a fetch waits.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      memerr
);

  arb_state_t state_q, state_d;
  logic       memerr_q, memerr_d;
  logic       d_req_c;
  logic       take_i_c;

  assign d_req_c = dREN | dWEN;
  assign memerr  = memerr_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      memerr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      memerr_q <= memerr_d;
    end
  end

`ifdef ARB_FAIR_EN
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_q, starve_d;
  logic             starve_sat;

  assign starve_sat = (starve_q == CNT_W'(STARVE_LIMIT));
  assign take_i_c   = iREN && starve_sat;

  // Counts data grants that jumped ahead of a waiting fetch.
  always_comb begin
    starve_d = starve_q;
    if (!iREN || (state_q == IDLE && state_d == IGRANT)) begin
      starve_d = '0;
    end else if (state_q == IDLE && state_d == DGRANT && !starve_sat) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) starve_q <= '0;
    else       starve_q <= starve_d;
  end
`else
  // Limit only matters when fairness is compiled in.
  logic unused_limit;
  assign unused_limit = ^STARVE_LIMIT;
  assign take_i_c     = 1'b0;
`endif

  // Next state and the combinational RAM/cache steering for the current grant.
  always_comb begin
    state_d  = state_q;
    memerr_d = memerr_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    unique case (state_q)
      IDLE: begin
        if (take_i_c)     state_d = IGRANT;
        else if (d_req_c) state_d = DGRANT;
        else if (iREN)    state_d = IGRANT;
      end
      IGRANT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        iload   = ramload;
        iwait   = !(iREN && ramstate == ACCESS);
        if (ramstate == ERROR) memerr_d = 1'b1;
        if (!iREN || ramstate == ACCESS || ramstate == ERROR) state_d = IDLE;
      end
      DGRANT: begin
        // A simultaneous read and write is serviced as the write.
        ramREN   = dREN & ~dWEN;
        ramWEN   = dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dload    = ramload;
        dwait    = !(d_req_c && ramstate == ACCESS);
        if (ramstate == ERROR) memerr_d = 1'b1;
        if (!d_req_c || ramstate == ACCESS || ramstate == ERROR) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: randomized RAM timing and cache traffic checked
// against a word-level memory model; directed cases for latency, priority, errors, reset.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int unsigned LIMIT = 4;

  logic      CLK = 1'b0;
  logic      nRST;
  logic      iREN, dREN, dWEN;
  word_t     iaddr, daddr, dstore;
  logic      iwait, dwait, ramREN, ramWEN, memerr;
  word_t     iload, dload, ramaddr, ramstore, ramload;
  ramstate_t ramstate;

  typedef struct {
    bit    wr;
    word_t data;
  } dexp_t;

  int        checks = 0;
  int        errors = 0;
  word_t     iq[$];
  dexp_t     dq[$];
  word_t     ram_mem[word_t];
  word_t     dmodel[word_t];
  ramstate_t script[$];
  bit        err_en = 1'b0;
  bit        err_exp = 1'b0;
  int        i_done = 0;
  int        d_done = 0;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .memerr(memerr)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got nothing expected an event", name);
  endtask

  function automatic word_t ifunc(input word_t a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic word_t ram_rd(input word_t a);
    return ram_mem.exists(a) ? ram_mem[a] : ifunc(a);
  endfunction

  function automatic ramstate_t rand_state();
    int r;
    r = int'($urandom_range(0, 99));
    if (err_en && r < 8) return ERROR;
    if (r < 45) return ACCESS;
    if (r < 75) return BUSY;
    return FREE;
  endfunction

  // RAM model: new status/data shortly after each edge while a request is presented.
  initial begin
    ramstate = FREE;
    ramload  = '0;
    forever begin
      @(posedge CLK);
      #2;
      if (nRST && (ramREN || ramWEN)) begin
        if (script.size() > 0) ramstate = script.pop_front();
        else                   ramstate = rand_state();
      end else begin
        ramstate = FREE;
      end
      ramload = ram_rd(ramaddr);
    end
  end

  // Monitor: completions pop the scoreboard; RAM writes and error history tracked here.
  initial begin
    forever begin
      @(negedge CLK);
      if (nRST) begin
        check("memerr", 32'(memerr), 32'(err_exp));
        check("ram_en_excl", 32'(ramREN & ramWEN), 32'd0);
        if (!iwait) begin
          check("iwait_on_access", 32'(ramstate), 32'(ACCESS));
          if (iq.size() == 0) fail("iwait_unexpected");
          else check("iload", iload, iq.pop_front());
          i_done++;
        end
        if (!dwait) begin
          dexp_t e;
          check("dwait_on_access", 32'(ramstate), 32'(ACCESS));
          if (dq.size() == 0) fail("dwait_unexpected");
          else begin
            e = dq.pop_front();
            if (!e.wr) check("dload", dload, e.data);
          end
          d_done++;
        end
        if (ramstate == ACCESS && ramWEN) ram_mem[ramaddr] = ramstore;
        if (ramstate == ERROR && (ramREN || ramWEN)) err_exp = 1'b1;
      end
    end
  end

  task automatic ifetch(input word_t a, input word_t exp, output int lat);
    iq.push_back(exp);
    iaddr = a;
    iREN  = 1'b1;
    lat   = 0;
    do begin
      @(negedge CLK);
      lat++;
    end while (iwait && lat < 3000);
    if (iwait) fail("ifetch_timeout");
    @(posedge CLK);
    #1;
    iREN = 1'b0;
  endtask

  // op: 0 read, 1 write, 2 read+write (serviced as write)
  task automatic dop(input int op, input word_t a, input word_t v, input bit keep);
    int n;
    bit wr;
    wr = (op != 0);
    if (wr) begin
      dmodel[a] = v;
      dq.push_back('{1'b1, '0});
    end else begin
      dq.push_back('{1'b0, dmodel.exists(a) ? dmodel[a] : ifunc(a)});
    end
    daddr  = a;
    dstore = v;
    dREN   = (op != 1);
    dWEN   = wr;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (dwait && n < 3000);
    if (dwait) fail("dop_timeout");
    @(posedge CLK);
    #1;
    if (!keep) begin
      dREN = 1'b0;
      dWEN = 1'b0;
    end
  endtask

  initial begin
    repeat (60000) @(posedge CLK);
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int lat;
    int d0;
    int d_at_i;
    int n;
    nRST = 1'b0;
    iREN = 1'b1; dREN = 1'b1; dWEN = 1'b1;
    iaddr = 32'h44; daddr = 32'h88; dstore = 32'h1234_5678;
    ram_mem[32'h40] = 32'h8C01_0004;

    // Requests held during reset must not reach the RAM.
    repeat (2) @(negedge CLK);
    check("rst_ramREN", 32'(ramREN), 32'd0);
    check("rst_ramWEN", 32'(ramWEN), 32'd0);
    check("rst_iwait", 32'(iwait), 32'd1);
    check("rst_dwait", 32'(dwait), 32'd1);
    check("rst_ramaddr", ramaddr, 32'd0);
    check("rst_ramstore", ramstore, 32'd0);
    check("rst_memerr", 32'(memerr), 32'd0);
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;

    // Fetch with two BUSY cycles before ACCESS.
    @(posedge CLK); #1;
    script = '{BUSY, BUSY, ACCESS};
    ifetch(32'h40, 32'h8C01_0004, lat);
    check("fetch_latency", 32'(lat), 32'd4);

    // Simultaneous requests: data first, fetch on the following IDLE.
    d0 = d_done;
    fork
      dop(0, 32'h100, 32'h0, 1'b0);
      begin
        ifetch(32'h2000, ifunc(32'h2000), lat);
        check("prio_d_before_i", 32'(d_done - d0), 32'd1);
      end
      begin
        repeat (2) @(negedge CLK);
        check("prio_ramaddr", ramaddr, 32'h100);
        check("prio_ramREN", 32'(ramREN), 32'd1);
      end
    join

    // Store steering, then read-back; then a read+write pair treated as a write.
    fork
      dop(1, 32'h200, 32'hDEAD_BEEF, 1'b0);
      begin
        n = 0;
        while (!ramWEN && n < 50) begin @(negedge CLK); n++; end
        if (!ramWEN) fail("store_no_ramWEN");
        check("store_ramREN", 32'(ramREN), 32'd0);
        check("store_ramstore", ramstore, 32'hDEAD_BEEF);
        check("store_ramaddr", ramaddr, 32'h200);
      end
    join
    dop(0, 32'h200, 32'h0, 1'b0);
    dop(2, 32'h204, 32'h0BAD_CAFE, 1'b0);
    dop(0, 32'h204, 32'h0, 1'b0);

    // RAM error mid-fetch: sticky flag, fetch retried from IDLE.
    script = '{BUSY, ERROR, BUSY, ACCESS};
    ifetch(32'h3000, ifunc(32'h3000), lat);
    check("err_retry_latency", 32'(lat), 32'd6);
    check("err_sticky", 32'(memerr), 32'd1);

    // Data held continuously while a fetch waits.
    d0 = d_done;
    d_at_i = 0;
    fork
      begin
        ifetch(32'h4000, ifunc(32'h4000), lat);
        d_at_i = d_done - d0;
      end
      for (int k = 0; k < 8; k++) dop(0, 32'h1000_0000 + 32'(4 * k), 32'h0, k < 7);
    join
`ifdef ARB_FAIR_EN
    check("starve_grants", 32'(d_at_i), 32'(LIMIT));
`else
    check("starve_grants", 32'(d_at_i), 32'd8);
`endif

    // Reset during a BUSY data grant aborts it with no completion.
    @(posedge CLK); #1;
    script = '{BUSY, BUSY, BUSY, BUSY, BUSY, BUSY, BUSY, BUSY};
    daddr = 32'h1000_0040;
    dREN  = 1'b1;
    n = 0;
    do begin @(negedge CLK); n++; end while (!ramREN && n < 50);
    if (!ramREN) fail("rst_test_no_grant");
    #1;
    nRST = 1'b0;
    err_exp = 1'b0;
    #1;
    check("midrst_ramREN", 32'(ramREN), 32'd0);
    check("midrst_ramWEN", 32'(ramWEN), 32'd0);
    check("midrst_dwait", 32'(dwait), 32'd1);
    check("midrst_memerr", 32'(memerr), 32'd0);
    script.delete();
    @(posedge CLK); #1;
    nRST = 1'b1;
    @(negedge CLK);
    check("post_rst_idle_ramREN", 32'(ramREN), 32'd0);
    check("post_rst_idle_dwait", 32'(dwait), 32'd1);
    dop(0, 32'h1000_0040, 32'h0, 1'b0);

    // Randomized concurrent traffic with RAM errors enabled.
    err_en = 1'b1;
    fork
      for (int k = 0; k < 40; k++) begin
        word_t a;
        a = 32'h1000 + 32'(4 * $urandom_range(0, 255));
        repeat ($urandom_range(0, 3)) @(posedge CLK);
        ifetch(a, ifunc(a), lat);
      end
      for (int k = 0; k < 40; k++) begin
        word_t a;
        a = 32'h1000_0000 + 32'(4 * $urandom_range(0, 15));
        repeat ($urandom_range(0, 3)) @(posedge CLK);
        dop(int'($urandom_range(0, 2)), a, $urandom, 1'b0);
      end
    join
    err_en = 1'b0;

    repeat (3) @(negedge CLK);
    check("iq_drained", 32'(iq.size()), 32'd0);
    check("dq_drained", 32'(dq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
